// File: rtl/ascii_uart_pkg.sv
// Shared constants and FSM state types for the ASCII line streamer.
// Used by the top-level streamer and its byte serializer.
package ascii_uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int LINE_CHARS      = 7;
    localparam int LINE_BYTES_CRLF = 9;

    // LOAD is resolved on the issuing edge, so the register never rests there
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } top_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } ser_state_t;

endpackage

// File: rtl/ascii_uart_streamer_tx.sv
// 8N1 byte serializer, LSB first, each bit held CLKS_PER_BIT cycles.
// A new byte offered in the last stop-bit cycle starts with no idle gap.
module uart_tx_byte
    import ascii_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       tx
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    ser_state_t    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          bit_end;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
        end
    end

    always_comb begin
        bit_end    = (timer == T_LAST);
        byte_done  = (state == S_STOP) && bit_end;
        byte_ready = (state == S_IDLE) || byte_done;
        state_n    = state;
        timer_n    = bit_end ? '0 : timer + TW'(1);
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        tx_n       = tx;
        unique case (state)
            S_IDLE: begin
                timer_n = '0;
                tx_n    = 1'b1;
                if (byte_valid) begin
                    shreg_n = byte_data;
                    tx_n    = 1'b0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n   = S_DATA;
                    bit_idx_n = '0;
                    tx_n      = shreg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 4'd7) begin
                        state_n = S_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        tx_n      = shreg[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_valid) begin
                        shreg_n = byte_data;
                        tx_n    = 1'b0;
                        state_n = S_START;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ascii_uart_streamer.sv
// Captures a seven-character reading, optionally appends CR/LF, and
// streams the line out as back-to-back 8N1 UART bytes.
module ascii_uart_streamer
    import ascii_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter bit APPEND_CRLF  = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] ch0,
    input  logic [7:0] ch1,
    input  logic [7:0] ch2,
    input  logic [7:0] ch3,
    input  logic [7:0] ch4,
    input  logic [7:0] ch5,
    input  logic [7:0] ch6,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam logic [3:0] LAST_IDX = APPEND_CRLF ?
        4'(LINE_BYTES_CRLF - 1) : 4'(LINE_CHARS - 1);

    top_state_t state, state_n;
    logic [3:0] idx, idx_n;
    logic [7:0] line_buf [LINE_BYTES_CRLF];
    logic       accept;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_done;
    logic [7:0] byte_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            line_buf[0] <= ch0;
            line_buf[1] <= ch1;
            line_buf[2] <= ch2;
            line_buf[3] <= ch3;
            line_buf[4] <= ch4;
            line_buf[5] <= ch5;
            line_buf[6] <= ch6;
            line_buf[7] <= ASCII_CR;
            line_buf[8] <= ASCII_LF;
        end
    end

    // First byte comes straight from ch0 so tx drops the cycle after start
    always_comb begin
        accept = start && byte_ready &&
                 (state == ST_IDLE || state == ST_DONE);
        state_n    = state;
        idx_n      = idx;
        byte_valid = 1'b0;
        byte_data  = ch0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                state_n = ST_IDLE;
                if (accept) begin
                    state_n    = ST_SEND;
                    idx_n      = '0;
                    byte_valid = 1'b1;
                end
            end
            ST_SEND: begin
                if (byte_done) begin
                    if (idx == LAST_IDX) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n      = idx + 4'd1;
                        byte_valid = 1'b1;
                        byte_data  = line_buf[idx_n];
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_SEND);
    assign done = (state == ST_DONE);

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock     (clock),
        .reset_n   (reset_n),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .byte_done (byte_done),
        .tx        (tx)
    );

endmodule
